// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: baud divisors for a 50 MHz clock, parity modes,
// transmitter state encoding and the parity helper.
package uart_tx_pkg;

  localparam int unsigned DATA_W  = 8;

  localparam int unsigned B115200 = 434;
  localparam int unsigned B57600  = 868;
  localparam int unsigned B38400  = 1302;
  localparam int unsigned B19200  = 2604;
  localparam int unsigned B9600   = 5208;
  localparam int unsigned B4800   = 10417;
  localparam int unsigned B2400   = 20833;
  localparam int unsigned B1200   = 41667;
  localparam int unsigned B300    = 166667;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Line value of the parity bit: even parity makes the total count of ones even.
  function automatic logic parity_bit(input logic [DATA_W-1:0] b, input int unsigned mode);
    return (mode == PAR_ODD) ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD-1 while enabled, held at zero otherwise,
// and flags the last cycle of every bit period.
module uart_baud_tick #(
  parameter int unsigned BAUD = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (BAUD < 2) ? 1 : $clog2(BAUD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD - 1);

  if (BAUD < 2) begin : g_bad_baud
    $error("uart_baud_tick: BAUD must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// 8-bit asynchronous serial transmitter, LSB first, optional parity and
// one or two stop bits; tx comes straight from a flop and idles high.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned BAUD      = B115200,
  parameter int unsigned PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              tx
);

  localparam bit   HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [2:0]        idx_q;
  logic              stop_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              tick;

  uart_baud_tick #(
    .BAUD (BAUD)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .tick (tick)
  );

  // tx is loaded on each transition with the value of the bit being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_START;
            shift_q <= data;
            par_q   <= parity_bit(data, PARITY);
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_q <= {1'b0, shift_q[DATA_W-1:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              if (HAS_PAR) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_q == STOP_LAST) begin
              state_q <= ST_IDLE;
              stop_q  <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              stop_q <= stop_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parameter sets run side by side, each with
// its own driver pushing expected bytes and a line-level receiver model checking tx.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int unsigned NCFG     = 4;
  localparam int unsigned CFG_BAUD [NCFG] = '{4, 4, 4, 5};
  localparam int unsigned CFG_PAR  [NCFG] = '{0, 1, 2, 1};
  localparam int unsigned CFG_STOP [NCFG] = '{1, 2, 1, 2};
  localparam int unsigned NRAND    = 6;
  localparam int unsigned WAIT_MAX = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  task automatic check(input int cfg, input bit ok, input string name,
                       input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cfg%0d %s: actual=%0h required=%0h", cfg, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned B     = CFG_BAUD[g];
    localparam int unsigned P     = CFG_PAR[g];
    localparam int unsigned S     = CFG_STOP[g];
    localparam int unsigned NBITS = 1 + 8 + ((P != 0) ? 1 : 0) + S;
    localparam int unsigned FLEN  = NBITS * B;

    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       ready;
    logic       busy;
    logic       tx;
    logic       mon_en;
    logic [7:0] exp_q[$];

    uart_tx #(
      .BAUD      (B),
      .PARITY    (P),
      .STOP_BITS (S)
    ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .data  (data),
      .ready (ready),
      .busy  (busy),
      .tx    (tx)
    );

    task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < int'(WAIT_MAX)) begin
        @(negedge clk);
        n++;
      end
      check(g, ready === 1'b1, "ready_wait", longint'(ready), 1);
    endtask

    task automatic send(input logic [7:0] b);
      wait_ready();
      start = 1'b1;
      data  = b;
      exp_q.push_back(b);
      @(negedge clk);
      start = 1'b0;
      data  = 8'($urandom);
    endtask

    // Driver
    initial begin
      logic [7:0] dir [4];
      logic       prev;
      int         n_tr;
      int         n;
      dir    = '{8'hA5, 8'h07, 8'h00, 8'hFF};
      rst    = 1'b1;
      start  = 1'b0;
      data   = 8'h00;
      mon_en = 1'b0;
      repeat (3) @(negedge clk);
      check(g, tx === 1'b1, "reset_tx", longint'(tx), 1);
      check(g, ready === 1'b1, "reset_ready", longint'(ready), 1);
      check(g, busy === 1'b0, "reset_busy", longint'(busy), 0);
      rst = 1'b0;

      // Abort a frame with a 3-cycle reset
      start = 1'b1;
      data  = 8'hA5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check(g, ready === 1'b0 && busy === 1'b1, "midframe_busy", longint'({ready, busy}), 1);
      rst = 1'b1;
      @(negedge clk);
      check(g, tx === 1'b1 && ready === 1'b1 && busy === 1'b0, "reset_abort",
            longint'({tx, ready, busy}), 6);
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      n_tr = 0;
      prev = tx;
      repeat (2 * FLEN) begin
        @(negedge clk);
        if (tx !== prev) n_tr++;
        prev = tx;
      end
      check(g, n_tr == 0 && tx === 1'b1, "quiet_after_reset", n_tr, 0);
      mon_en = 1'b1;

      for (int i = 0; i < 4; i++) send(dir[i]);

      // A request mid-frame must be ignored
      send(8'h00);
      repeat (9) @(negedge clk);
      start = 1'b1;
      data  = 8'hFF;
      check(g, ready === 1'b0, "ignored_ready", longint'(ready), 0);
      @(negedge clk);
      start = 1'b0;

      for (int i = 0; i < int'(NRAND); i++) begin
        repeat ($urandom_range(3, 0)) @(negedge clk);
        send(8'($urandom));
      end

      // Back-to-back with start held high; data changes right after each accept
      wait_ready();
      exp_q.push_back(8'h55);
      exp_q.push_back(8'h33);
      start = 1'b1;
      data  = 8'h55;
      @(negedge clk);
      data = 8'h33;
      n = 0;
      while (ready !== 1'b1 && n < int'(WAIT_MAX)) begin
        @(negedge clk);
        n++;
      end
      check(g, n == int'(FLEN), "b2b_ready_time", n, FLEN);
      @(negedge clk);
      n++;
      check(g, tx === 1'b0 && n == int'(FLEN) + 1, "b2b_gap", n, FLEN + 1);
      start = 1'b0;
      data  = 8'($urandom);

      wait_ready();
      repeat (2 * FLEN) @(negedge clk);
      check(g, exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
      n_done++;
    end

    // Monitor: receiver model decoding tx against the queued bytes
    initial begin
      forever begin
        @(negedge clk);
        if (mon_en === 1'b1 && tx === 1'b0) begin
          check(g, exp_q.size() != 0, "spurious_frame", exp_q.size(), 1);
          if (exp_q.size() == 0) begin
            repeat (FLEN) @(negedge clk);
          end else begin
            logic [7:0]  b;
            logic [7:0]  dec;
            bit          exp_bits [12];
            int          nb;
            int          ones;
            int          mism;
            int          rdy_bad;
            b    = exp_q.pop_front();
            dec  = 8'h00;
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(b[i]);
            nb = 0;
            exp_bits[nb] = 1'b0;
            nb = nb + 1;
            for (int i = 0; i < 8; i++) begin
              exp_bits[nb] = b[i];
              nb = nb + 1;
            end
            if (P == PAR_EVEN) begin
              exp_bits[nb] = (ones % 2) == 1;
              nb = nb + 1;
            end else if (P == PAR_ODD) begin
              exp_bits[nb] = (ones % 2) == 0;
              nb = nb + 1;
            end
            for (int s = 0; s < int'(S); s++) begin
              exp_bits[nb] = 1'b1;
              nb = nb + 1;
            end
            mism    = 0;
            rdy_bad = 0;
            for (int k = 0; k < int'(FLEN); k++) begin
              if (k != 0) @(negedge clk);
              if (tx !== exp_bits[k / int'(B)]) mism++;
              if (ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
              if (k / int'(B) >= 1 && k / int'(B) <= 8 && k % int'(B) == int'(B) / 2)
                dec[k / int'(B) - 1] = tx;
            end
            @(negedge clk);
            check(g, mism == 0, "frame_waveform", mism, 0);
            check(g, dec == b, "data_decode", dec, b);
            check(g, rdy_bad == 0, "busy_during_frame", rdy_bad, 0);
            check(g, ready === 1'b1 && busy === 1'b0 && tx === 1'b1, "ready_return",
                  longint'({ready, busy, tx}), 5);
          end
        end
      end
    end
  end

  initial begin
    int n = 0;
    while (n_done < int'(NCFG) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(-1, n_done == int'(NCFG), "all_done", n_done, NCFG);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
